// File: rtl/mem_access_unit.sv
// Load/store initiator over a word-only data memory: sub-word load extraction, SB/SH read-modify-write, error checks.
// Loads/SW/errors respond 1 cycle after accept; SB/SH hold req_ready low for the extra write cycle.
module mem_access_unit #(
    parameter int DEPTH_WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_we,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rdata
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic [31:0] r_rmw_addr;
    logic [31:0] r_rmw_word;
    logic [31:0] r_rmw_pc;

    logic        w_accept;
    logic        w_misalign;
    logic        w_oor;
    logic        w_err;
    logic        w_is_load;
    logic        w_is_sub_store;
    logic [31:0] w_aligned;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    // Decode and error checks for the request presented this cycle
    always_comb begin
        w_accept       = req_valid && (r_state == ST_IDLE) && !reset;
        w_is_load      = (req_op <= OP_LBU);
        w_is_sub_store = (req_op == OP_SH) || (req_op == OP_SB);
        w_aligned      = {req_addr[31:2], 2'b00};
        w_misalign     = 1'b0;
        if ((req_op == OP_LW) || (req_op == OP_SW))
            w_misalign = (req_addr[1:0] != 2'b00);
        else if ((req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH))
            w_misalign = req_addr[0];
        w_oor = (req_addr >= ADDR_LIMIT);
        w_err = w_misalign || w_oor;
    end

    always_comb begin
        w_half = req_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (req_addr[1:0])
            2'd0:    w_byte = dm_rdata[7:0];
            2'd1:    w_byte = dm_rdata[15:8];
            2'd2:    w_byte = dm_rdata[23:16];
            default: w_byte = dm_rdata[31:24];
        endcase
        case (req_op)
            OP_LW:   w_load_data = dm_rdata;
            OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_data = {16'h0, w_half};
            OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_data = {24'h0, w_byte};
            default: w_load_data = 32'h0;
        endcase
    end

    // Merge store data into the current memory word for SB/SH
    always_comb begin
        w_merged = dm_rdata;
        if (req_op == OP_SH) begin
            if (req_addr[1])
                w_merged[31:16] = req_wdata[15:0];
            else
                w_merged[15:0]  = req_wdata[15:0];
        end else begin
            case (req_addr[1:0])
                2'd0:    w_merged[7:0]   = req_wdata[7:0];
                2'd1:    w_merged[15:8]  = req_wdata[7:0];
                2'd2:    w_merged[23:16] = req_wdata[7:0];
                default: w_merged[31:24] = req_wdata[7:0];
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        dm_addr     = 32'h0;
        dm_wdata    = 32'h0;
        dm_we       = 1'b0;
        dm_pc       = 32'h0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_err) begin
                    dm_addr = w_aligned;
                    if (req_op == OP_SW) begin
                        dm_wdata = req_wdata;
                        dm_we    = 1'b1;
                        dm_pc    = req_pc;
                    end
                    if (w_is_sub_store)
                        w_state_nxt = ST_RMW_WR;
                end
            end
            ST_RMW_WR: begin
                dm_addr     = r_rmw_addr;
                dm_wdata    = r_rmw_word;
                dm_we       = 1'b1;
                dm_pc       = r_rmw_pc;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (reset)
            dm_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_rmw_addr  <= 32'h0;
            r_rmw_word  <= 32'h0;
            r_rmw_pc    <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_err   <= 1'b0;
            if (r_state == ST_RMW_WR) begin
                r_rsp_valid <= 1'b1;
            end else if (w_accept) begin
                if (w_err) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                end else if (w_is_load) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= w_load_data;
                end else if (req_op == OP_SW) begin
                    r_rsp_valid <= 1'b1;
                end else begin
                    r_rmw_addr <= w_aligned;
                    r_rmw_word <= w_merged;
                    r_rmw_pc   <= req_pc;
                end
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE) && !reset;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory attached to the dm_* port, plus a store-level reference model.
module tb_mem_access_unit;

    localparam int DEPTH = 3072;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        req_ready, rsp_valid, rsp_err, dm_we;
    logic [31:0] rsp_data, dm_addr, dm_wdata, dm_pc, dm_rdata;

    logic [31:0] mem  [0:DEPTH-1];
    logic [31:0] refm [0:DEPTH-1];

    int tests = 0;
    int fails = 0;

    // Model state: a pending sub-word store commits only when its write cycle completes
    logic        m_busy = 1'b0;
    int          m_pidx = 0;
    logic [31:0] m_pword = 32'h0, m_ppc = 32'h0;
    logic        exp_vld = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_data = 32'h0;
    logic        last_acc = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_pc(dm_pc),
        .dm_rdata(dm_rdata)
    );

    assign dm_rdata = (dm_addr < 32'(4 * DEPTH)) ? mem[dm_addr[13:2]] : 32'h0;

    always @(posedge clk) begin
        if (dm_we && dm_addr < 32'(4 * DEPTH))
            mem[dm_addr[13:2]] <= dm_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int access_size(input logic [2:0] op);
        if (op == LW || op == SW) return 4;
        if (op == LH || op == LHU || op == SH) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> (8 * addr[1:0]);
        case (op)
            LH:      return 32'($signed(sh[15:0]));
            LHU:     return {16'h0, sh[15:0]};
            LB:      return 32'($signed(sh[7:0]));
            LBU:     return {24'h0, sh[7:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [31:0] addr,
                                                input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] mask;
        mask = ((op == SB) ? 32'hFF : 32'hFFFF) << (8 * addr[1:0]);
        return (old & ~mask) | ((wd << (8 * addr[1:0])) & mask);
    endfunction

    // Registered response check, one cycle after the model step that predicted it
    task automatic tick();
        @(negedge clk);
        chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_vld});
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
        chk("rsp_data", rsp_data, exp_data);
    endtask

    task automatic apply(input logic rst, input logic vld, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
        logic e_rdy, acc, err, e_we, n_vld, n_err;
        logic [31:0] e_addr, e_wdata, e_pc, n_data;
        int idx;
        reset = rst; req_valid = vld; req_op = op; req_addr = addr; req_wdata = wd; req_pc = pc;
        #1;
        e_rdy = !m_busy && !rst;
        chk("req_ready", {31'h0, req_ready}, {31'h0, e_rdy});
        acc = vld && e_rdy;
        err = (addr % access_size(op) != 0) || (addr >= 32'(4 * DEPTH));
        idx = int'(addr >> 2);
        e_we = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_pc = 32'h0;
        if (m_busy && !rst) begin
            e_we = 1'b1; e_addr = 32'(m_pidx * 4); e_wdata = m_pword; e_pc = m_ppc;
        end else if (acc && !err && op == SW) begin
            e_we = 1'b1; e_addr = addr & ~32'h3; e_wdata = wd; e_pc = pc;
        end
        chk("dm_we", {31'h0, dm_we}, {31'h0, e_we});
        if (e_we) begin
            chk("dm_addr", dm_addr, e_addr);
            chk("dm_wdata", dm_wdata, e_wdata);
            chk("dm_pc", dm_pc, e_pc);
        end
        n_vld = 1'b0; n_err = 1'b0; n_data = 32'h0;
        if (rst) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            refm[m_pidx] = m_pword;
            m_busy = 1'b0;
            n_vld = 1'b1;
        end else if (acc) begin
            n_vld = 1'b1;
            if (err) begin
                n_err = 1'b1;
            end else if (op <= LBU) begin
                n_data = load_value(op, addr, refm[idx]);
            end else if (op == SW) begin
                refm[idx] = wd;
            end else begin
                n_vld = 1'b0;
                m_busy = 1'b1; m_pidx = idx; m_ppc = pc;
                m_pword = store_merge(op, addr, refm[idx], wd);
            end
        end
        exp_vld = n_vld; exp_err = n_err; exp_data = n_data;
        last_acc = acc;
    endtask

    initial begin
        logic        have_req;
        logic [2:0]  r_op;
        logic [31:0] r_addr, r_wd, r_pc;
        logic        r_rst;
        int          mism;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = (i < 16) ? $urandom : 32'h0;
            refm[i] = mem[i];
        end
        mem[0] = 32'h1234_80F0; refm[0] = 32'h1234_80F0;
        mem[1] = 32'h8765_4321; refm[1] = 32'h8765_4321;
        mem[2] = 32'h0000_5678; refm[2] = 32'h0000_5678;

        reset = 1'b1; req_valid = 1'b0; req_op = LW; req_addr = 0; req_wdata = 0; req_pc = 0;
        tick(); apply(1, 0, LW, 0, 0, 0);
        tick(); apply(1, 0, LW, 0, 0, 0);
        tick();
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);

        apply(0, 1, LW, 32'h4, 0, 32'h100);
        tick();
        chk("lw_lit", rsp_data, 32'h8765_4321);
        chk("lw_lit_vld", {31'h0, rsp_valid}, 32'h1);
        apply(0, 1, LB, 32'h0, 0, 32'h104);  tick(); chk("lb_lit", rsp_data, 32'hFFFF_FFF0);
        apply(0, 1, LBU, 32'h0, 0, 32'h108); tick(); chk("lbu_lit", rsp_data, 32'h0000_00F0);
        apply(0, 1, LH, 32'h0, 0, 32'h10C);  tick(); chk("lh_lit", rsp_data, 32'hFFFF_80F0);
        apply(0, 1, LHU, 32'h2, 0, 32'h110); tick(); chk("lhu_lit", rsp_data, 32'h0000_1234);

        apply(0, 1, SW, 32'h4, 32'h1111_1111, 32'h114); tick();
        apply(0, 1, SB, 32'h5, 32'h0000_00AB, 32'h118);
        chk("sb_c0_we", {31'h0, dm_we}, 32'h0);
        tick();
        apply(0, 1, LW, 32'h4, 0, 32'h11C);
        chk("sb_c1_rdy", {31'h0, req_ready}, 32'h0);
        chk("sb_c1_addr", dm_addr, 32'h4);
        chk("sb_c1_wdata", dm_wdata, 32'h1111_AB11);
        tick();
        chk("sb_c2_vld", {31'h0, rsp_valid}, 32'h1);
        apply(0, 1, LW, 32'h4, 0, 32'h11C); tick(); chk("lw_after_sb", rsp_data, 32'h1111_AB11);

        apply(0, 1, SH, 32'hA, 32'h0000_BEEF, 32'h120); tick();
        apply(0, 0, LW, 0, 0, 0); tick();
        apply(0, 1, LW, 32'h8, 0, 32'h124); tick(); chk("lw_after_sh", rsp_data, 32'hBEEF_5678);

        apply(0, 1, LW, 32'h2, 0, 32'h128);    tick(); chk("err_lw", {31'h0, rsp_err}, 32'h1);
        apply(0, 1, SH, 32'h3, 32'h55, 32'h12C); tick(); chk("err_sh", {31'h0, rsp_err}, 32'h1);
        apply(0, 1, SW, 32'h3000, 32'hDEAD_BEEF, 32'h130);
        chk("err_sw_we", {31'h0, dm_we}, 32'h0);
        tick(); chk("err_sw", {31'h0, rsp_err}, 32'h1);

        apply(0, 1, SB, 32'h4, 32'hCD, 32'h134); tick();
        apply(1, 0, LW, 0, 0, 0);
        chk("rst_rmw_we", {31'h0, dm_we}, 32'h0);
        tick(); chk("rst_rmw_vld", {31'h0, rsp_valid}, 32'h0);
        apply(0, 0, LW, 0, 0, 0);
        chk("rst_rmw_rdy", {31'h0, req_ready}, 32'h1);
        tick();
        apply(0, 1, LW, 32'h4, 0, 32'h138); tick(); chk("rst_rmw_word", rsp_data, 32'h1111_AB11);

        have_req = 1'b0; r_op = LW; r_addr = 0; r_wd = 0; r_pc = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!have_req && $urandom_range(0, 9) < 7) begin
                have_req = 1'b1;
                r_op = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 19))
                    0:       r_addr = $urandom_range(12280, 12300);
                    1:       r_addr = $urandom;
                    default: r_addr = $urandom_range(0, 63);
                endcase
                r_wd = $urandom;
                r_pc = $urandom;
            end
            r_rst = ($urandom_range(0, 99) == 0);
            apply(r_rst, have_req, r_op, r_addr, r_wd, r_pc);
            if (last_acc) have_req = 1'b0;
            tick();
        end

        apply(0, 0, LW, 0, 0, 0);
        tick();
        mism = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== refm[i]) mism++;
        chk("memory_image", 32'(mism), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator sitting between the MEM pipeline stage and the word-only data memory.
- The data memory offers only a combinational word read and a full-word synchronous write. This unit adds the missing pieces on top of it:
  - byte/halfword load extraction with sign or zero extension;
  - byte/halfword stores as a two-cycle read-modify-write;
  - alignment and range error checks.
- It stalls the pipeline during the read-modify-write.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words in the data memory. Valid byte addresses are 0 .. 4*DEPTH_WORDS-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  access request present this cycle
- req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data; the low byte/half is used for SB/SH
- req_pc  in  32  PC of the instruction, forwarded for the memory's write log
- req_ready  out  1  1 when a request is accepted this cycle; pipeline stalls when 0
- rsp_valid  out  1  one-cycle pulse, one cycle after an access completes
- rsp_data  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or out-of-range access
- dm_addr  out  32  word-aligned address to the memory
- dm_wdata  out  32  full-word write data
- dm_we  out  1  full-word write enable
- dm_pc  out  32  PC presented with the write
- dm_rdata  in  32  combinational read data from the memory at dm_addr

Behaviour:
- State machine: IDLE and RMW_WR. Reset puts the unit in IDLE and sets rsp_valid=0, rsp_data=0, rsp_err=0, internal buffers=0.
- Combinational outputs under reset:
  - dm_we is forced 0 whenever reset=1.
  - dm_addr, dm_wdata and dm_pc are 0 in IDLE with no request.
- req_ready = (state==IDLE) && !reset.
- A request is accepted when req_valid && req_ready.
- Error check on accept:
  - misaligned if LW/SW have addr[1:0]!=0, or LH/LHU/SH have addr[0]!=0;
  - out of range if addr >= 4*DEPTH_WORDS.
  - On error: no memory access and dm_we=0. Next cycle rsp_valid=1, rsp_err=1, rsp_data=0. State stays IDLE.
- Loads (IDLE, accept cycle):
  - dm_addr = {addr[31:2],2'b00}.
  - On the clock edge, rsp_data is registered from dm_rdata:
    - LW: the whole word;
    - LH/LHU: halfword addr[1] (1 = bits 31:16), sign- or zero-extended;
    - LB/LBU: byte addr[1:0] (3 = bits 31:24), sign- or zero-extended.
  - Next cycle rsp_valid=1, rsp_err=0. Latency is 1 cycle and a new request may be accepted every cycle.
- SW (IDLE, accept cycle): dm_addr = aligned address, dm_wdata = req_wdata, dm_we=1, dm_pc = req_pc. Next cycle rsp_valid=1, rsp_data=0.
- SH/SB, cycle 0 (IDLE, accept):
  - dm_addr = aligned address, dm_we=0.
  - Latch the merged word: dm_rdata with the addressed half/byte replaced by req_wdata[15:0]/[7:0].
  - Latch the aligned address and req_pc, then go to RMW_WR.
- SH/SB, cycle 1 (RMW_WR):
  - req_ready=0, so requests presented this cycle are not accepted and must be held.
  - dm_addr = latched address, dm_wdata = merged word, dm_we=1, dm_pc = latched pc.
  - Go to IDLE. Next cycle rsp_valid=1, rsp_data=0.
- Back-to-back: a load issued right after an SB/SH (to the same word) is accepted in the cycle after RMW_WR and reads the already-written word.
- Reset mid-operation: reset asserted while in RMW_WR aborts the write (dm_we=0), returns to IDLE and clears rsp_valid.
- rsp_valid is exactly one cycle wide per accepted request. It is never asserted for non-accepted cycles.

Test Plan:
- Reset, then LW at 0x0000_0004 with memory word 1 = 0x8765_4321 -> next cycle rsp_valid=1, rsp_data=0x8765_4321, rsp_err=0; req_ready stays 1.
- Memory word 0 = 0x1234_80F0:
  - LB addr 0x0 -> 0xFFFF_FFF0;
  - LBU addr 0x0 -> 0x0000_00F0;
  - LH addr 0x0 -> 0xFFFF_80F0;
  - LHU addr 0x2 -> 0x0000_1234.
- SB addr 0x5, wdata 0x0000_00AB, word 1 = 0x1111_1111:
  - cycle 0: dm_we=0, req_ready=1, state→RMW_WR;
  - cycle 1: req_ready=0, dm_we=1, dm_addr=0x4, dm_wdata=0x1111_AB11;
  - cycle 2: rsp_valid=1.
  - A following LW 0x4 returns 0x1111_AB11.
- SH addr 0xA, wdata 0xBEEF -> RMW writes word 2 with bits 31:16=0xBEEF and the low half preserved.
- Errors:
  - LW 0x2 -> rsp_err=1, dm_we never 1;
  - SH 0x3 -> rsp_err=1, dm_we never 1;
  - SW 0x3000 (DEPTH_WORDS=3072) -> rsp_err=1, no write.
- Reset asserted during the RMW_WR cycle of an SB -> dm_we=0 that cycle, the memory word is unchanged, rsp_valid=0, req_ready=1 after reset deasserts.
